frame_ring_writer: RTL and testbench
====================================

# frame_ring_writer

Parametrised multi-buffer successor to the single-frame memory writer. Accepts a pixel AXI-Stream (one pixel per beat, `tuser` = start of frame, `tlast` = end of line) and packs it into INCR write bursts toward the AXI write master. Frames go round-robin into NUM_BUFFERS frame buffers in DRAM. Tracks frames not yet consumed downstream, and drops whole frames when all buffers are occupied.

## Interface
- DATA_WIDTH, 32: pixel/beat width in bits, a power of two, 8 or more.
- ADDR_WIDTH, 32: address width.
- NUM_BUFFERS, 4: frame buffers in the ring, 1 or more.
- BURST_LEN, 16: maximum beats per burst, 1..256.
- BASE_ADDR, 0: address of buffer 0.
- BUFFER_STRIDE, 32'h0010_0000: byte distance between buffers.
- One clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  DATA_WIDTH  pixel.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid and tready are both high.
- s_axis_tlast  in  1  end of line; closes the current burst.
- s_axis_tuser  in  1  first pixel of a frame.
- frame_width, frame_height  in  16 each  geometry, sampled at SOF.
- start_write  out  1  one-cycle burst request.
- write_busy  in  1  master cannot take a request.
- write_addr  out  ADDR_WIDTH  burst start byte address.
- write_len  out  8  beats minus 1.
- write_size  out  3  $clog2(DATA_WIDTH/8), constant.
- write_burst  out  2  2'b01 (INCR), constant.
- write_data  out  DATA_WIDTH  burst data.
- write_strb  out  DATA_WIDTH/8  all ones.
- write_data_valid  out  1  data beat valid.
- write_data_ready  in  1  master accepts the data beat.
- write_last  out  1  final beat of the burst.
- frame_ready  out  1  one-cycle pulse when a frame is fully written.
- base_addr_out  out  ADDR_WIDTH  base address of the last completed frame.
- frame_index  out  $clog2(NUM_BUFFERS) (min 1)  buffer index of the last completed frame.
- frame_consumed  in  1  downstream has released the oldest pending frame.
- frames_pending  out  $clog2(NUM_BUFFERS+1)  completed frames not yet consumed.
- frame_dropped  out  1  one-cycle pulse when a frame is dropped.
- frame_error  out  1  one-cycle pulse when SOF arrives mid-frame.

## Operation
- Internal burst buffer holds BURST_LEN words. Pixel target = frame_width*frame_height, computed at 32 bits and latched at SOF. Buffer base = BASE_ADDR + wr_buf*BUFFER_STRIDE.
- **IDLE** (tready=1)
  - Beats without tuser are discarded.
  - Beat with tuser and target 0: ignored.
  - Beat with tuser and frames_pending==NUM_BUFFERS: go to DROP and pulse frame_dropped.
  - Any other beat with tuser: store it as pixel 0 and go to FILL.
- **FILL** (tready=1): store beats. The burst closes on the beat that reaches BURST_LEN, carries tlast, or is the frame's final pixel; then go to ISSUE.
- **ISSUE** (tready=0)
  - On the first cycle with write_busy=0, pulse start_write and go to SEND.
  - write_addr = base + (first pixel index of burst)*(DATA_WIDTH/8).
  - write_len = beats-1.
- **SEND** (tready=0)
  - write_data_valid=1; advance one word per write_data_ready.
  - write_last is high on the final beat.
  - After the last handshake: if the frame is complete, pulse frame_ready, load base_addr_out and frame_index, advance wr_buf (NUM_BUFFERS-1 wraps to 0), and go to IDLE; otherwise go to FILL.
- **DROP** (tready=1): discard beats until target beats have been seen, then go to IDLE. A tuser beat in DROP is evaluated as a new SOF in that cycle, using the IDLE rules.
- **SOF mid-frame**: a tuser beat in FILL with frame pixel count > 0:
  - Pulse frame_error.
  - Discard the partial burst.
  - Restart the frame in the same wr_buf, with this beat as pixel 0.
- **frames_pending**
  - +1 on frame_ready; -1 on frame_consumed.
  - Both in the same cycle: unchanged.
  - frame_consumed at 0: ignored.
  - Increment at NUM_BUFFERS is impossible by construction.
- tlast never ends a frame; only the pixel count does.

## Timing
- Reset values:
  - tready, start_write, write_data_valid, write_last, frame_ready, frame_dropped, frame_error: 0.
  - write_addr, write_len, frame_index, frames_pending: 0.
  - base_addr_out: BASE_ADDR.
  - State: IDLE.
- Reset mid-burst abandons all data; outputs reach their reset values after the reset edge.
- The burst-closing beat is accepted at edge N. tready is 0 from N. Earliest start_write is in cycle N+1; first write_data_valid is in cycle N+2.
- write_addr and write_len hold stable from start_write until the last data handshake. write_data holds until accepted.
- frame_ready is asserted the cycle after the final handshake. frames_pending updates at the same edge.
- frame_dropped and frame_error are asserted the cycle after the triggering beat.

## Test plan
- **Single frame:** W=4, H=2, tdata=i*100, tlast at i=3,7 -> bursts (BASE, len 3, data 0..300) and (BASE+16, len 3, data 400..700); frame_ready with base_addr_out=BASE, frame_index=0, frames_pending=1.
- **Ring wrap:** 5 frames, frame_consumed after each -> base_addr_out BASE, +S, +2S, +3S, BASE (S = BUFFER_STRIDE); frames_pending returns to 0.
- **Full ring:** no frame_consumed -> frame 5 pulses frame_dropped, no start_write, 8 beats accepted, frames_pending stays 4; one frame_consumed -> 3, and frame 6 is written to buffer 0.
- **Long line:** W=40, H=1, BURST_LEN=16 -> write_len 15, 15, 7 at offsets +0, +64, +128.
- **Mid-frame SOF:** tuser at beat 5 of a W=4, H=2 frame -> frame_error pulse; first burst written, beat 4 discarded; frame restarts at offset 0 in the same buffer and completes.
- **Backpressure and reset:** write_busy held high 10 cycles -> start_write waits; write_data_ready toggling -> data held until accepted; rst asserted mid-SEND -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/frame_ring_writer.sv
// rtl/frame_ring_writer.sv - pixel stream packed into INCR bursts across a ring of DRAM frame buffers
module frame_ring_writer #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    NUM_BUFFERS   = 4,
    parameter int                    BURST_LEN     = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter logic [ADDR_WIDTH-1:0] BUFFER_STRIDE = 'h0010_0000,
    localparam int IDX_W  = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1,
    localparam int PEND_W = $clog2(NUM_BUFFERS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic [15:0]             frame_width,
    input  logic [15:0]             frame_height,
    output logic                    start_write,
    input  logic                    write_busy,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [7:0]              write_len,
    output logic [2:0]              write_size,
    output logic [1:0]              write_burst,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    write_data_valid,
    input  logic                    write_data_ready,
    output logic                    write_last,
    output logic                    frame_ready,
    output logic [ADDR_WIDTH-1:0]   base_addr_out,
    output logic [IDX_W-1:0]        frame_index,
    input  logic                    frame_consumed,
    output logic [PEND_W-1:0]       frames_pending,
    output logic                    frame_dropped,
    output logic                    frame_error
);
    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int BIDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_SEND, S_DROP} state_t;
    state_t state, next_state;

    logic [DATA_WIDTH-1:0] buf_mem [2**BIDX_W];
    logic [CNT_W-1:0]      fill_cnt, fill_next, close_beats;
    logic [BIDX_W-1:0]     send_idx;
    logic [31:0]           pix_cnt, pix_next, target, burst_start, close_start, sof_target;
    logic [IDX_W-1:0]      wr_buf;
    logic [ADDR_WIDTH-1:0] buf_base;
    logic beat, sof_store, store, drop_start, drop_beat, sof_err, close;
    logic data_hs, frame_done, ring_full, consume_ok, accept_next;

    assign write_size  = 3'($clog2(DATA_WIDTH / 8));
    assign write_burst = 2'b01;
    assign write_strb  = '1;

    assign beat       = s_axis_tvalid && s_axis_tready;
    assign sof_target = 32'(frame_width) * 32'(frame_height);
    assign fill_next  = fill_cnt + CNT_W'(1);
    assign pix_next   = pix_cnt + 32'd1;
    assign ring_full  = frames_pending == PEND_W'(NUM_BUFFERS);
    assign buf_base   = BASE_ADDR + ADDR_WIDTH'(wr_buf) * BUFFER_STRIDE;

    assign start_write      = (state == S_ISSUE) && !write_busy;
    assign write_data_valid = (state == S_SEND);
    assign write_data       = buf_mem[send_idx];
    assign write_last       = (state == S_SEND) && (8'(send_idx) == write_len);
    assign data_hs          = write_data_valid && write_data_ready;
    assign frame_done       = data_hs && write_last && (pix_cnt == target);
    assign consume_ok       = frame_consumed && (frames_pending != '0);
    assign close_beats      = sof_store ? CNT_W'(1) : fill_next;
    assign close_start      = sof_store ? 32'd0 : burst_start;
    assign accept_next      = (next_state == S_IDLE) || (next_state == S_FILL) || (next_state == S_DROP);

    always_comb begin
        next_state = state;
        sof_store  = 1'b0;
        store      = 1'b0;
        drop_start = 1'b0;
        drop_beat  = 1'b0;
        sof_err    = 1'b0;
        close      = 1'b0;
        // A tuser beat is only ever accepted in IDLE, FILL or DROP and always starts a new frame.
        if (beat && s_axis_tuser) begin
            sof_err = (state == S_FILL);
            if (sof_target == 32'd0) begin
                next_state = S_IDLE;
            end else if (ring_full) begin
                drop_start = 1'b1;
                next_state = (sof_target == 32'd1) ? S_IDLE : S_DROP;
            end else begin
                sof_store  = 1'b1;
                close      = s_axis_tlast || (BURST_LEN == 1) || (sof_target == 32'd1);
                next_state = close ? S_ISSUE : S_FILL;
            end
        end else begin
            case (state)
                S_FILL: if (beat) begin
                    store      = 1'b1;
                    close      = (fill_next == CNT_W'(BURST_LEN)) || s_axis_tlast || (pix_next == target);
                    next_state = close ? S_ISSUE : S_FILL;
                end
                S_ISSUE: if (!write_busy) next_state = S_SEND;
                S_SEND: if (data_hs && write_last) next_state = (pix_cnt == target) ? S_IDLE : S_FILL;
                S_DROP: if (beat) begin
                    drop_beat  = 1'b1;
                    next_state = (pix_next >= target) ? S_IDLE : S_DROP;
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sof_store || store) buf_mem[sof_store ? BIDX_W'(0) : fill_cnt[BIDX_W-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            s_axis_tready  <= 1'b0;
            frame_ready    <= 1'b0;
            frame_dropped  <= 1'b0;
            frame_error    <= 1'b0;
            write_addr     <= '0;
            write_len      <= '0;
            frame_index    <= '0;
            frames_pending <= '0;
            base_addr_out  <= BASE_ADDR;
            fill_cnt       <= '0;
            send_idx       <= '0;
            pix_cnt        <= '0;
            target         <= '0;
            burst_start    <= '0;
            wr_buf         <= '0;
        end else begin
            state         <= next_state;
            s_axis_tready <= accept_next;
            frame_ready   <= frame_done;
            frame_dropped <= drop_start;
            frame_error   <= sof_err;
            // pix_cnt doubles as the beat counter while a frame is being dropped.
            if (sof_store || drop_start) begin
                target      <= sof_target;
                pix_cnt     <= 32'd1;
                burst_start <= '0;
                fill_cnt    <= CNT_W'(1);
            end else if (store) begin
                fill_cnt <= fill_next;
                pix_cnt  <= pix_next;
            end else if (drop_beat) begin
                pix_cnt <= pix_next;
            end
            if (close) begin
                write_addr <= buf_base + ADDR_WIDTH'(close_start) * ADDR_WIDTH'(DATA_WIDTH / 8);
                write_len  <= 8'(close_beats - CNT_W'(1));
            end
            if (data_hs) begin
                send_idx <= write_last ? '0 : send_idx + BIDX_W'(1);
                if (write_last) begin
                    fill_cnt    <= '0;
                    burst_start <= pix_cnt;
                end
            end
            if (frame_done) begin
                base_addr_out <= buf_base;
                frame_index   <= wr_buf;
                wr_buf        <= (wr_buf == IDX_W'(NUM_BUFFERS - 1)) ? '0 : wr_buf + IDX_W'(1);
            end
            if (frame_done && !consume_ok)      frames_pending <= frames_pending + PEND_W'(1);
            else if (!frame_done && consume_ok) frames_pending <= frames_pending - PEND_W'(1);
        end
    end
endmodule

// File: tb/tb_frame_ring_writer.sv
// tb/tb_frame_ring_writer.sv - randomized scoreboard bench for frame_ring_writer
module tb_frame_ring_writer;
    localparam int DW = 32, AW = 32, NB = 4, BL = 16;
    localparam logic [31:0] BASE = 32'h1000_0000, STRIDE = 32'h0010_0000;

    logic clk = 0, rst = 1;
    logic [31:0] s_axis_tdata = '0;
    logic s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0, s_axis_tuser = 0;
    logic [15:0] frame_width = '0, frame_height = '0;
    logic start_write, write_busy = 0, write_data_valid, write_data_ready = 1, write_last;
    logic [31:0] write_addr, write_data, base_addr_out;
    logic [7:0] write_len;
    logic [2:0] write_size;
    logic [1:0] write_burst;
    logic [3:0] write_strb;
    logic frame_ready, frame_consumed = 0, frame_dropped, frame_error;
    logic [1:0] frame_index;
    logic [2:0] frames_pending;

    always #5 clk = ~clk;

    frame_ring_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BUFFERS(NB), .BURST_LEN(BL),
                        .BASE_ADDR(BASE), .BUFFER_STRIDE(STRIDE)) dut (
        .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .frame_width(frame_width), .frame_height(frame_height), .start_write(start_write),
        .write_busy(write_busy), .write_addr(write_addr), .write_len(write_len),
        .write_size(write_size), .write_burst(write_burst), .write_data(write_data),
        .write_strb(write_strb), .write_data_valid(write_data_valid),
        .write_data_ready(write_data_ready), .write_last(write_last), .frame_ready(frame_ready),
        .base_addr_out(base_addr_out), .frame_index(frame_index), .frame_consumed(frame_consumed),
        .frames_pending(frames_pending), .frame_dropped(frame_dropped), .frame_error(frame_error));

    int tests = 0, fails = 0;
    logic [39:0] exp_bursts [$];
    logic [32:0] exp_data [$];
    logic [33:0] exp_frames [$];
    int exp_drops = 0, seen_drops = 0, exp_errors = 0, seen_errors = 0;
    int m_buf = 0, m_pending = 0, bp_mode = 0;
    bit mon_off = 0, rand_gaps = 0, hold_pend = 0;
    logic [31:0] hold_data, cur_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave side of the write master: idle, random, held busy, or stalled data.
    initial forever begin
        @(posedge clk); #1;
        case (bp_mode)
            1: begin write_busy = ($urandom_range(0, 3) == 0); write_data_ready = ($urandom_range(0, 2) != 0); end
            2: begin write_busy = 1; write_data_ready = 1; end
            3: begin write_busy = 0; write_data_ready = 0; end
            default: begin write_busy = 0; write_data_ready = 1; end
        endcase
    end

    always @(negedge clk) begin
        logic [39:0] b;
        logic [32:0] d;
        logic [33:0] f;
        if (!rst && !mon_off) begin
            if (start_write) begin
                if (exp_bursts.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL burst_unexpected: addr %0h len %0d, none expected", write_addr, write_len);
                end else begin
                    b = exp_bursts.pop_front();
                    chk("burst_addr", 64'(write_addr), 64'(b[39:8]));
                    chk("burst_len", 64'(write_len), 64'(b[7:0]));
                    cur_addr = b[39:8];
                end
                chk("start_while_busy", 64'(write_busy), 64'(0));
            end
            if (hold_pend) begin
                chk("valid_held", 64'(write_data_valid), 64'(1));
                chk("data_held", 64'(write_data), 64'(hold_data));
            end
            if (write_data_valid && write_data_ready) begin
                if (exp_data.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL data_unexpected: data %0h, none expected", write_data);
                end else begin
                    d = exp_data.pop_front();
                    chk("wdata", 64'(write_data), 64'(d[31:0]));
                    chk("wlast", 64'(write_last), 64'(d[32]));
                    chk("addr_stable", 64'(write_addr), 64'(cur_addr));
                end
            end
            hold_pend = write_data_valid && !write_data_ready;
            hold_data = write_data;
            if (frame_ready) begin
                if (exp_frames.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_unexpected: base %0h index %0d, none expected", base_addr_out, frame_index);
                end else begin
                    f = exp_frames.pop_front();
                    chk("frame_base", 64'(base_addr_out), 64'(f[33:2]));
                    chk("frame_index", 64'(frame_index), 64'(f[1:0]));
                end
            end
            if (frame_dropped) seen_drops++;
            if (frame_error) seen_errors++;
        end
    end

    // Reference: split each row at BL words or at the row end; the frame's final pixel also closes.
    task automatic model_bursts(input logic [31:0] pix[$], input int w, input int total);
        int start = 0, cnt = 0;
        logic [31:0] base = BASE + 32'(m_buf) * STRIDE;
        for (int i = 0; i < pix.size(); i++) begin
            cnt++;
            if (cnt == BL || (i % w) == w - 1 || i == total - 1) begin
                exp_bursts.push_back({base + 32'(start * 4), 8'(cnt - 1)});
                for (int j = start; j <= i; j++) exp_data.push_back({(j == i), pix[j]});
                start = i + 1;
                cnt = 0;
            end
        end
    endtask

    task automatic model_frame(input logic [31:0] pix[$], input int w);
        model_bursts(pix, w, pix.size());
        exp_frames.push_back({BASE + 32'(m_buf) * STRIDE, 2'(m_buf)});
        m_buf = (m_buf + 1) % NB;
        m_pending++;
    endtask

    task automatic drive_beat(input logic [31:0] d, input bit u, input bit l);
        int t = 0;
        if (rand_gaps && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 0;
            @(negedge clk);
        end
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1;
        while (!s_axis_tready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            tests++; fails++;
            $display("FAIL tready_timeout: tready %0d required 1", s_axis_tready);
            s_axis_tvalid = 0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        s_axis_tvalid = 0;
    endtask

    task automatic send_frame(input int w, input int h, input bit fixed);
        logic [31:0] pix[$];
        frame_width = 16'(w);
        frame_height = 16'(h);
        for (int i = 0; i < w * h; i++) pix.push_back(fixed ? 32'(i * 100) : 32'($urandom));
        if (m_pending == NB) exp_drops++;
        else model_frame(pix, w);
        for (int i = 0; i < w * h; i++) drive_beat(pix[i], i == 0, (i % w) == w - 1);
    endtask

    task automatic mid_sof();
        logic [31:0] a[$], p[$];
        frame_width = 16'd4;
        frame_height = 16'd2;
        for (int i = 0; i < 5; i++) a.push_back(32'($urandom));
        for (int i = 0; i < 8; i++) p.push_back(32'($urandom));
        model_bursts(a, 4, 8);
        exp_errors++;
        model_frame(p, 4);
        for (int i = 0; i < 5; i++) drive_beat(a[i], i == 0, (i % 4) == 3);
        for (int i = 0; i < 8; i++) drive_beat(p[i], i == 0, (i % 4) == 3);
    endtask

    task automatic wait_quiet();
        int t = 0;
        while ((exp_bursts.size() != 0 || exp_data.size() != 0 || exp_frames.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            tests++; fails++;
            $display("FAIL quiet_timeout: %0d bursts %0d beats %0d frames outstanding, required 0",
                     exp_bursts.size(), exp_data.size(), exp_frames.size());
            exp_bursts.delete(); exp_data.delete(); exp_frames.delete();
        end
        repeat (3) @(negedge clk);
        chk("drops", 64'(seen_drops), 64'(exp_drops));
        chk("errors", 64'(seen_errors), 64'(exp_errors));
        chk("frames_pending", 64'(frames_pending), 64'(m_pending));
    endtask

    task automatic consume();
        frame_consumed = 1;
        @(negedge clk);
        frame_consumed = 0;
        if (m_pending > 0) m_pending--;
        @(negedge clk);
        chk("pending_after_consume", 64'(frames_pending), 64'(m_pending));
    endtask

    task automatic check_reset();
        chk("rst_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_start", 64'(start_write), 64'(0));
        chk("rst_valid", 64'(write_data_valid), 64'(0));
        chk("rst_last", 64'(write_last), 64'(0));
        chk("rst_frame_ready", 64'(frame_ready), 64'(0));
        chk("rst_dropped", 64'(frame_dropped), 64'(0));
        chk("rst_error", 64'(frame_error), 64'(0));
        chk("rst_addr", 64'(write_addr), 64'(0));
        chk("rst_len", 64'(write_len), 64'(0));
        chk("rst_index", 64'(frame_index), 64'(0));
        chk("rst_pending", 64'(frames_pending), 64'(0));
        chk("rst_base", 64'(base_addr_out), 64'(BASE));
        chk("const_size_burst_strb", 64'({write_size, write_burst, write_strb}), 64'({3'd2, 2'b01, 4'hf}));
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 0;
        @(negedge clk);
        chk("tready_after_reset", 64'(s_axis_tready), 64'(1));

        send_frame(4, 2, 1);
        wait_quiet();
        consume();

        for (int k = 0; k < 5; k++) begin
            send_frame(4, 2, 0);
            wait_quiet();
            consume();
        end

        for (int k = 0; k < 4; k++) begin
            send_frame(3, 2, 0);
            wait_quiet();
        end
        send_frame(4, 2, 0);
        wait_quiet();
        consume();
        send_frame(4, 2, 0);
        wait_quiet();
        repeat (4) consume();

        send_frame(40, 1, 0);
        wait_quiet();
        consume();

        mid_sof();
        wait_quiet();
        consume();

        bp_mode = 1;
        rand_gaps = 1;
        for (int k = 0; k < 20; k++) begin
            send_frame($urandom_range(1, 24), $urandom_range(1, 3), 0);
            wait_quiet();
            if ($urandom_range(0, 1) == 1) consume();
        end
        while (m_pending > 0) consume();
        bp_mode = 0;
        rand_gaps = 0;

        bp_mode = 2;
        send_frame(4, 1, 0);
        repeat (10) begin
            @(negedge clk);
            chk("busy_hold_no_start", 64'(start_write), 64'(0));
        end
        bp_mode = 0;
        wait_quiet();
        consume();

        bp_mode = 3;
        send_frame(4, 1, 0);
        t = 0;
        while (!write_data_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_reached", 64'(write_data_valid), 64'(1));
        mon_off = 1;
        rst = 1;
        @(negedge clk);
        check_reset();
        rst = 0;
        bp_mode = 0;
        exp_bursts.delete(); exp_data.delete(); exp_frames.delete();
        m_pending = 0;
        m_buf = 0;
        hold_pend = 0;
        exp_drops = seen_drops;
        exp_errors = seen_errors;
        @(negedge clk);
        mon_off = 0;
        @(negedge clk);
        send_frame(4, 2, 1);
        wait_quiet();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
